// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq : sequential multiply / divide unit with HI/LO result registers.
//
// Multiplies (shift-add) and divides (restoring shift-subtract) take one
// iteration per clock for WIDTH iterations. Signed operations run on operand
// magnitudes and fix the result signs when HI/LO are written. MTHI/MTLO write
// HI/LO directly from operand a without leaving IDLE.
//
// Ports
//   clk    in   clock, all state updated on the rising edge
//   rst_n  in   asynchronous active-low reset
//   a      in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//   b      in   WIDTH  multiplier / divisor
//   op     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                      100 MTHI, 101 MTLO, 11x reserved (ignored)
//   start  in   request, honoured only in IDLE
//   busy   out  iterative operation in progress (CALC)
//   done   out  one-cycle pulse after HI/LO were written by an arithmetic op
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // Conditional two's-complement negation, single and double width.
    function automatic logic [WIDTH-1:0] f_cneg_w(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (WIDTH'(0) - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cneg_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? ((2*WIDTH)'(0) - v) : v;
    endfunction

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic               r_is_div;
    logic               r_neg_q;    // sign of product / quotient
    logic               r_neg_r;    // sign of remainder (follows the dividend)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div_zero;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Acceptance decode: only signed ops (op[0]=0) contribute operand signs.
    assign w_accept   = start && (r_state == S_IDLE);
    assign w_sa       = ~op[0] & a[WIDTH-1];
    assign w_sb       = ~op[0] & b[WIDTH-1];
    assign w_mag_a    = f_cneg_w(a, w_sa);
    assign w_mag_b    = f_cneg_w(b, w_sb);
    assign w_div_zero = op[1] && (b == '0);

    // Multiply step: conditionally add multiplicand to the upper half, then
    // shift the whole accumulator right, keeping the adder carry.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_mag_a} : '0);
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and subtract
    // the divisor when it fits. The true difference is always below 2^WIDTH,
    // so a WIDTH-bit subtraction is exact whenever w_ge is set.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_mag_b});
    assign w_rem_sub  = w_shift[WIDTH-1:0] - r_mag_b;
    assign w_div_next = {(w_ge ? w_rem_sub : w_shift[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_ge};

    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    // Final results are formed from the last iteration's output so HI/LO are
    // written on the same edge that enters FIN.
    assign w_prod   = f_cneg_2w(w_acc_next, r_neg_q);
    assign w_res_hi = r_is_div ? f_cneg_w(w_acc_next[2*WIDTH-1:WIDTH], r_neg_r)
                               : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? f_cneg_w(w_acc_next[WIDTH-1:0], r_neg_q)
                               : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!op[2]) begin
                            r_mag_a  <= w_mag_a;
                            r_mag_b  <= w_mag_b;
                            r_is_div <= op[1];
                            r_neg_q  <= w_sa ^ w_sb;
                            r_neg_r  <= w_sa;
                            r_cnt    <= '0;
                            r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_mag_a}
                                              : {{WIDTH{1'b0}}, w_mag_b};
                            if (w_div_zero) begin
                                // Divide by zero bypasses iteration entirely.
                                r_hi    <= a;
                                r_lo    <= '1;
                                r_state <= S_FIN;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end else if (!op[1]) begin
                            if (op[0]) begin
                                r_lo <= a;
                            end else begin
                                r_hi <= a;
                            end
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_CALC);
    assign done = (r_state == S_FIN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port a, input, 32 bits: operand 1 (multiplicand, dividend, or MTHI/MTLO data).
REQ-005 The block SHALL have port b, input, 32 bits: operand 2 (multiplier or divisor).
REQ-006 The block SHALL have port op, input, 3 bits, encoded as: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
REQ-007 The block SHALL have port start, input, 1 bit: request, sampled on the rising edge.
REQ-008 The block SHALL have port busy, output, 1 bit: an iterative operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse, high when HI/LO have been updated by MULT/MULTU/DIV/DIVU.
REQ-010 The block SHALL have port hi, output, 32 bits: the HI register.
REQ-011 The block SHALL have port lo, output, 32 bits: the LO register.

Function
REQ-012 The state machine SHALL have exactly three states:
- IDLE
- CALC
- FIN
REQ-013 An operation SHALL be accepted only when start=1 in IDLE; start in CALC or FIN SHALL be ignored with no effect on state, hi or lo.
REQ-014 On accepting MULT/MULTU/DIV/DIVU, the block SHALL:
- latch operand magnitudes, result sign and op;
- clear the iteration counter;
- move to CALC, with busy=1 from the next cycle.
REQ-015 CALC SHALL perform exactly one iteration per clock, for 32 iterations: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 After the 32nd iteration the block SHALL write hi/lo, enter FIN and drop busy.
- done=1 for exactly one cycle in FIN, then return to IDLE.
- Latency: done is visible after the 32nd rising edge following the accepting edge.
REQ-017 MULTU SHALL produce {hi,lo} = the unsigned 64-bit product a*b.
REQ-018 MULT SHALL produce {hi,lo} = the two's-complement 64-bit product of signed a and signed b.
REQ-019 DIVU SHALL produce lo = unsigned quotient and hi = unsigned remainder.
REQ-020 DIV SHALL produce a quotient truncated toward zero, with the remainder taking the sign of the dividend.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0x00000000, with no flag raised.
REQ-022 Divide by zero (b=0, DIV or DIVU) SHALL be detected at acceptance and handled as follows:
- skip CALC and go directly to FIN;
- write lo=0xFFFFFFFF and hi=a;
- done is visible after the first edge following acceptance;
- busy stays 0.
REQ-023 MTHI/MTLO accepted in IDLE SHALL write hi=a (or lo=a) at the accepting edge, stay in IDLE, and assert neither busy nor done.
REQ-024 Reserved op codes with start=1 SHALL be ignored.
REQ-025 hi/lo SHALL hold their previous values throughout CALC and change only at the FIN-entry edge or on an MTHI/MTLO write.
REQ-026 Operand inputs a, b and op SHALL be don't-care after the accepting edge, since the block uses internal copies.
REQ-027 Back-to-back operation: start=1 during the FIN cycle SHALL be ignored; the earliest new acceptance is the cycle after FIN.

Reset
REQ-028 When rst_n=0, asynchronously and regardless of state:
- state SHALL become IDLE;
- busy=0, done=0, hi=0x00000000, lo=0x00000000;
- the counter and internal operand registers SHALL be cleared.
REQ-029 Reset asserted during CALC SHALL abort the operation, so that no done pulse and no hi/lo write occur after rst_n returns high.
REQ-030 The first acceptance SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 32 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 32 cycles.
REQ-032 MULT a=0xFFFFFFFD (-3) b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7) b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU a=0x00000064 b=0 -> done one cycle after acceptance, lo=0xFFFFFFFF, hi=0x00000064, busy never high; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Start DIVU 100/7, pulse start with MULTU 3*3 at cycle 5, and pulse rst_n=0 in a separate run at cycle 10 -> in the first run the second start is ignored and the result is lo=14, hi=2; in the reset run hi=lo=0, busy=0 and no later done.
REQ-035 MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0; busy=0 and done=0 throughout.
